sq_wave_gen: RTL and testbench
==============================

Name: sq_wave_gen

Overview:
- Multi-channel programmable square-wave generator, clocked from the PLL-derived global clock.
- Each channel divides `clk` by 2×half-period; the half-period is reprogrammable at runtime through a valid/ready write port.
- New values take effect glitch-free at the channel's next toggle boundary.
- Used for test clocks, pixel/strobe timing and bring-up probes on output pins.

Parameters:
- NUM_CH, 4, number of independent output channels (1..16).
- DIV_W, 16, width of half-period counter and config value.
- RESET_HALF, 64, half-period loaded into every channel at reset (64 gives clk/128).
- CH_W, $clog2(NUM_CH) min 1, width of channel select (derived, not overridden).

Ports:
- clk  in  1  global clock (PLL output via global buffer)
- rst  in  1  asynchronous, active-high reset
- en  in  1  global run enable; low freezes all counters and outputs
- cfg_valid  in  1  write request
- cfg_ready  out  1  write accepted when valid&ready
- cfg_ch  in  CH_W  target channel
- cfg_half  in  DIV_W  new half-period in clk cycles; 0 = stop channel
- sq_out  out  NUM_CH  square-wave outputs, registered
- busy  out  NUM_CH  per-channel pending-update flag, registered

Behaviour:
- Clock and reset: one clock, `clk`; `rst` asynchronous, active-high.
- Per-channel registers: half (active), pend (shadow), pend_v, cnt[DIV_W-1:0], out.
- Reset values: half=RESET_HALF, pend=0, pend_v=0, cnt=0, sq_out=0, busy=0.
- Reset is asynchronous, so asserting rst mid-period clears state immediately; no partial update survives.
- Running (half≠0, en=1): cnt increments each cycle.
  - When cnt==half-1: cnt←0 and out toggles (boundary).
  - At a boundary with pend_v=1: half←pend and pend_v←0, in the same edge.
  - The new value governs the following half-period.
- First edge: after rst deasserts, sq_out[ch] rises at the end of cycle `half` (cnt 0..half-1); period is 2×half.
- Idle (half==0): cnt held 0, out forced 0.
  - If pend_v=1, half←pend on the next edge, with no boundary wait.
  - The channel restarts with out=0 and cnt=0.
- Loading half=0 at a boundary: out←0 on that same edge (the toggle is suppressed), and the channel goes idle.
- half==1: out toggles every cycle (clk/2).
- en=0: cnt, out and half frozen; pending writes are still accepted but apply only at a boundary while en=1, or immediately if idle.
- Handshake:
  - cfg_ready = !pend_v[cfg_ch] (combinational from registered state); at most one pending value per channel.
  - On valid&ready: pend[cfg_ch]←cfg_half and pend_v←1; busy mirrors pend_v.
  - cfg_ch ≥ NUM_CH: cfg_ready=1 and the write is silently dropped.
- Simultaneous write and boundary on the same channel:
  - pend_v was 0, so the write is captured into pend.
  - It does not bypass to half; it applies at the next boundary.
- Arithmetic: cnt compare is unsigned DIV_W-bit.
  - Writing a half smaller than the current cnt cannot occur, since writes only reach half at a boundary where cnt=0.

Optional Feature:
- Macro: SQ_WAVE_GEN_SYNC_EN.
- Defined: adds input sync_in (1 bit). A cycle with sync_in=1:
  - clears cnt and out of every running channel on the next edge;
  - applies all pending values immediately (phase-aligns all channels);
  - takes priority over boundary and en.
- Undefined: no sync_in port; channels are phase-related only through reset.

Decomposition:
- Package sq_wave_gen_pkg: DIV_W default, HALF_IDLE=0 constant, max channel count, clog2 helper.
- One sub-module, sq_wave_chan:
  - holds half/pend/pend_v/cnt/out for a single channel;
  - ports: clk, rst, en, wr, wr_half, out, busy.
- Top level: generate loop plus cfg decode/ready mux.

Test Plan (NUM_CH=4, DIV_W=16, RESET_HALF=64):
- Reset then en=1 -> all sq_out low for 64 cycles, rise together at cycle 64, period 128, 50% duty; busy=0.
- Write ch1 half=3 mid-period -> busy[1]=1, ch1 completes current 64-cycle half, then toggles every 3 cycles; ch0/2/3 unaffected.
- Two back-to-back writes to ch2 (10 then 5) -> second stalls with cfg_ready=0 until ch2 boundary; after it, half-periods 10 then 5 observed in order.
- Write ch3 half=0 -> sq_out[3] driven 0 at next boundary and stays 0. Then write half=2 -> restarts next cycle: low 2 cycles, high 2 cycles.
- Assert rst for 1 cycle mid-period with pending write on ch0 -> outputs 0 asynchronously, busy=0, pending discarded, 64-cycle restart; write to cfg_ch=5 (CH_W=2 masks to range, so test with NUM_CH=3, cfg_ch=3) -> accepted, no channel changes.
- (SYNC_EN) set ch0=4, ch1=6, pulse sync_in -> both cnt=0/out=0 next edge, subsequent rising edges coincide every 24 cycles.

Source files
------------

// File: rtl/sq_wave_gen_pkg.sv
// Shared constants and helpers for the sq_wave_gen square-wave generator.
// Optional macro SQ_WAVE_GEN_SYNC_EN adds a global phase-align input.
package sq_wave_gen_pkg;

    localparam int DIV_W_DEF = 16;
    localparam int HALF_IDLE = 0;
    localparam int MAX_CH    = 16;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_mode_e;

    // Channel-select width, never below one bit even for a single channel.
    function automatic int ch_width(input int n);
        int lim;
        lim = (n > MAX_CH) ? MAX_CH : n;
        return (lim <= 2) ? 1 : $clog2(lim);
    endfunction

endpackage

// File: rtl/sq_wave_chan.sv
// One square-wave channel: active/shadow half-period, counter and output.
// With SQ_WAVE_GEN_SYNC_EN defined, sync_in realigns the channel phase.
module sq_wave_chan
    import sq_wave_gen_pkg::*;
#(
    parameter int DIV_W      = DIV_W_DEF,
    parameter int RESET_HALF = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef SQ_WAVE_GEN_SYNC_EN
    input  logic             sync_in,
`endif
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_half,
    output logic             out,
    output logic             busy
);

    logic [DIV_W-1:0] half_q, half_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             pend_v_q, pend_v_d;
    logic             out_q, out_d;
    ch_mode_e         mode;
    logic             boundary;
    logic             sync;

    assign mode     = (half_q == DIV_W'(HALF_IDLE)) ? CH_IDLE : CH_RUN;
    assign boundary = (cnt_q == half_q - DIV_W'(1));

`ifdef SQ_WAVE_GEN_SYNC_EN
    assign sync = sync_in;
`else
    assign sync = 1'b0;
`endif

    always_comb begin
        half_d   = half_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        if (sync) begin
            cnt_d = '0;
            out_d = 1'b0;
            if (pend_v_q) begin
                half_d   = pend_q;
                pend_v_d = 1'b0;
            end
        end else if (mode == CH_IDLE) begin
            // Idle channels take a pending value at once, no boundary to wait for.
            cnt_d = '0;
            out_d = 1'b0;
            if (pend_v_q) begin
                half_d   = pend_q;
                pend_v_d = 1'b0;
            end
        end else if (en) begin
            if (boundary) begin
                cnt_d = '0;
                out_d = ~out_q;
                if (pend_v_q) begin
                    half_d   = pend_q;
                    pend_v_d = 1'b0;
                    if (pend_q == DIV_W'(HALF_IDLE)) begin
                        out_d = 1'b0;
                    end
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
        // A write is only taken while the shadow is empty, so it never races the load above.
        if (wr && !pend_v_q) begin
            pend_d   = wr_half;
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_q   <= DIV_W'(RESET_HALF);
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            cnt_q    <= '0;
            out_q    <= 1'b0;
        end else begin
            half_q   <= half_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    assign out  = out_q;
    assign busy = pend_v_q;

endmodule

// File: rtl/sq_wave_gen.sv
// Multi-channel programmable square-wave generator with valid/ready config port.
// Define SQ_WAVE_GEN_SYNC_EN to add the sync_in phase-align input.
module sq_wave_gen
    import sq_wave_gen_pkg::*;
#(
    parameter int  NUM_CH     = 4,
    parameter int  DIV_W      = DIV_W_DEF,
    parameter int  RESET_HALF = 64,
    localparam int CH_W       = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
`ifdef SQ_WAVE_GEN_SYNC_EN
    input  logic              sync_in,
`endif
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] sq_out,
    output logic [NUM_CH-1:0] busy
);

    logic [NUM_CH-1:0] wr;

    // Selects beyond NUM_CH report ready and match no channel, so the write is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~busy[i];
            end
        end
    end

    always_comb begin
        wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sq_wave_chan #(
            .DIV_W      (DIV_W),
            .RESET_HALF (RESET_HALF)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
`ifdef SQ_WAVE_GEN_SYNC_EN
            .sync_in (sync_in),
`endif
            .wr      (wr[g]),
            .wr_half (cfg_half),
            .out     (sq_out[g]),
            .busy    (busy[g])
        );
    end

endmodule

// File: tb/tb_sq_wave_gen.sv
// Self-checking bench for sq_wave_gen: per-cycle scoreboard plus scenario checks.
module tb_sq_wave_gen;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int RH  = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          sync_r = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_ch = '0;
    logic [DW-1:0] cfg_half = '0;
    logic [NCH-1:0] sq_out;
    logic [NCH-1:0] busy;

    logic          c3_valid = 1'b0;
    logic          c3_ready;
    logic [1:0]    c3_ch = '0;
    logic [DW-1:0] c3_half = '0;
    logic [2:0]    sq3;
    logic [2:0]    busy3;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [2*NCH-1:0] exp_q[$];

    int unsigned m_half[NCH];
    int unsigned m_pend[NCH];
    int unsigned m_rem[NCH];
    bit          m_pv[NCH];
    bit          m_out[NCH];

    always #5 clk = ~clk;

    sq_wave_gen #(.NUM_CH(NCH), .DIV_W(DW), .RESET_HALF(RH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
`ifdef SQ_WAVE_GEN_SYNC_EN
        .sync_in   (sync_r),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .sq_out    (sq_out),
        .busy      (busy)
    );

    sq_wave_gen #(.NUM_CH(3), .DIV_W(DW), .RESET_HALF(RH)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
`ifdef SQ_WAVE_GEN_SYNC_EN
        .sync_in   (sync_r),
`endif
        .cfg_valid (c3_valid),
        .cfg_ready (c3_ready),
        .cfg_ch    (c3_ch),
        .cfg_half  (c3_half),
        .sq_out    (sq3),
        .busy      (busy3)
    );

    // Reference model counts down the cycles remaining in the current half-period.
    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_half[i] = RH;
            m_pend[i] = 0;
            m_pv[i]   = 0;
            m_rem[i]  = RH;
            m_out[i]  = 0;
        end
    endtask

    function automatic bit model_ready(input int ch);
        if (ch >= NCH) return 1'b1;
        return !m_pv[ch];
    endfunction

    task automatic model_edge(input bit acc, input int ch, input int unsigned hv);
        for (int i = 0; i < NCH; i++) begin
            if (sync_r) begin
                if (m_pv[i]) begin
                    m_half[i] = m_pend[i];
                    m_pv[i]   = 0;
                end
                m_rem[i] = m_half[i];
                m_out[i] = 0;
            end else if (m_half[i] == 0) begin
                m_out[i] = 0;
                if (m_pv[i]) begin
                    m_half[i] = m_pend[i];
                    m_pv[i]   = 0;
                    m_rem[i]  = m_half[i];
                end
            end else if (en) begin
                if (m_rem[i] == 1) begin
                    if (m_pv[i]) begin
                        m_half[i] = m_pend[i];
                        m_pv[i]   = 0;
                    end
                    m_out[i] = (m_half[i] == 0) ? 1'b0 : !m_out[i];
                    m_rem[i] = m_half[i];
                end else begin
                    m_rem[i] = m_rem[i] - 1;
                end
            end
        end
        if (acc) begin
            m_pend[ch] = hv;
            m_pv[ch]   = 1;
        end
    endtask

    function automatic logic [2*NCH-1:0] model_pack();
        logic [2*NCH-1:0] v;
        for (int i = 0; i < NCH; i++) begin
            v[i]       = m_out[i];
            v[NCH + i] = m_pv[i];
        end
        return v;
    endfunction

    // One clock: check ready, push the expected post-edge state, clock, pop and compare.
    task automatic step();
        bit               rdy_exp;
        logic [2*NCH-1:0] e;
        logic [2*NCH-1:0] got;
        rdy_exp = model_ready(int'(cfg_ch));
        checks++;
        if (cfg_ready !== rdy_exp) begin
            errors++;
            $display("FAIL cfg_ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, rdy_exp);
        end
        model_edge(cfg_valid && rdy_exp, int'(cfg_ch), int'(cfg_half));
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        cyc++;
        got = {busy, sq_out};
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL scoreboard cyc=%0d got busy/out=%b exp=%b", cyc, got, e);
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic cycles_to_toggle(input int ch, output int n);
        logic prev;
        prev = sq_out[ch];
        n = -1;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (sq_out[ch] !== prev) begin
                n = k;
                return;
            end
        end
    endtask

    task automatic wr(input int ch, input int unsigned h, output int stalls);
        bit done;
        done      = 0;
        stalls    = 0;
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_half  = DW'(h);
        for (int k = 0; k < 400 && !done; k++) begin
            done = model_ready(ch);
            step();
            if (!done) stalls++;
        end
        cfg_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wr_timeout ch=%0d got=stalled exp=accepted", ch);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        sync_r    = 1'b0;
        cfg_valid = 1'b0;
        c3_valid  = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        checks++;
        if (sq_out !== 4'h0) begin errors++; $display("FAIL rst_out got=%b exp=0000", sq_out); end
        checks++;
        if (busy !== 4'h0) begin errors++; $display("FAIL rst_busy got=%b exp=0000", busy); end
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", cfg_ready); end
        en = 1'b1;
        cycles_to_toggle(0, n);
        checks++;
        if (n !== 64) begin errors++; $display("FAIL first_rise got=%0d exp=64", n); end
        checks++;
        if (sq_out !== 4'hF) begin errors++; $display("FAIL rise_together got=%b exp=1111", sq_out); end
        cycles_to_toggle(0, n);
        checks++;
        if (n !== 64) begin errors++; $display("FAIL high_time got=%0d exp=64", n); end
        cycles_to_toggle(0, n);
        checks++;
        if (n !== 64) begin errors++; $display("FAIL low_time got=%0d exp=64", n); end
    endtask

    task automatic test_write_mid();
        int n;
        int s;
        do_reset();
        en = 1'b1;
        steps(20);
        wr(1, 3, s);
        checks++;
        if (busy !== 4'b0010) begin errors++; $display("FAIL mid_busy got=%b exp=0010", busy); end
        cycles_to_toggle(1, n);
        checks++;
        if (n !== 43) begin errors++; $display("FAIL mid_finish got=%0d exp=43", n); end
        checks++;
        if (busy !== 4'b0000) begin errors++; $display("FAIL mid_busy_clr got=%b exp=0000", busy); end
        for (int r = 0; r < 2; r++) begin
            cycles_to_toggle(1, n);
            checks++;
            if (n !== 3) begin errors++; $display("FAIL mid_half3 got=%0d exp=3", n); end
        end
        steps(30);
    endtask

    task automatic test_back_to_back();
        int n;
        int s;
        do_reset();
        en = 1'b1;
        steps(5);
        wr(2, 10, s);
        checks++;
        if (s !== 0) begin errors++; $display("FAIL b2b_first_stall got=%0d exp=0", s); end
        wr(2, 5, s);
        checks++;
        if (s !== 58) begin errors++; $display("FAIL b2b_stall got=%0d exp=58", s); end
        cycles_to_toggle(2, n);
        checks++;
        if (n !== 9) begin errors++; $display("FAIL b2b_half10 got=%0d exp=9", n); end
        for (int r = 0; r < 2; r++) begin
            cycles_to_toggle(2, n);
            checks++;
            if (n !== 5) begin errors++; $display("FAIL b2b_half5 got=%0d exp=5", n); end
        end
    endtask

    task automatic test_idle();
        int n;
        int s;
        do_reset();
        en = 1'b1;
        steps(10);
        wr(3, 0, s);
        steps(53);
        checks++;
        if (sq_out !== 4'b0111) begin errors++; $display("FAIL idle_suppress got=%b exp=0111", sq_out); end
        steps(20);
        checks++;
        if (sq_out[3] !== 1'b0) begin errors++; $display("FAIL idle_hold got=%b exp=0", sq_out[3]); end
        wr(3, 2, s);
        cycles_to_toggle(3, n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL idle_restart got=%0d exp=3", n); end
        cycles_to_toggle(3, n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL idle_high got=%0d exp=2", n); end
    endtask

    task automatic test_enable();
        int n;
        int s;
        do_reset();
        en = 1'b1;
        steps(30);
        en = 1'b0;
        wr(0, 5, s);
        steps(20);
        checks++;
        if (busy !== 4'b0001) begin errors++; $display("FAIL en_busy got=%b exp=0001", busy); end
        checks++;
        if (sq_out !== 4'b0000) begin errors++; $display("FAIL en_frozen got=%b exp=0000", sq_out); end
        en = 1'b1;
        cycles_to_toggle(0, n);
        checks++;
        if (n !== 34) begin errors++; $display("FAIL en_resume got=%0d exp=34", n); end
        cycles_to_toggle(0, n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL en_new_half got=%0d exp=5", n); end
    endtask

    task automatic test_async_reset();
        int n;
        int s;
        do_reset();
        en = 1'b1;
        steps(70);
        wr(0, 7, s);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (sq_out !== 4'h0) begin errors++; $display("FAIL async_out got=%b exp=0000", sq_out); end
        checks++;
        if (busy !== 4'h0) begin errors++; $display("FAIL async_busy got=%b exp=0000", busy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycles_to_toggle(0, n);
        checks++;
        if (n !== 64) begin errors++; $display("FAIL async_restart got=%0d exp=64", n); end
        cycles_to_toggle(0, n);
        checks++;
        if (n !== 64) begin errors++; $display("FAIL async_discard got=%0d exp=64", n); end
    endtask

    task automatic test_out_of_range();
        do_reset();
        en       = 1'b1;
        c3_ch    = 2'd3;
        c3_half  = 16'd1;
        c3_valid = 1'b1;
        #1;
        checks++;
        if (c3_ready !== 1'b1) begin errors++; $display("FAIL oor_ready got=%b exp=1", c3_ready); end
        step();
        c3_valid = 1'b0;
        checks++;
        if (busy3 !== 3'b000) begin errors++; $display("FAIL oor_busy got=%b exp=000", busy3); end
        steps(62);
        checks++;
        if (sq3 !== 3'b000) begin errors++; $display("FAIL oor_low got=%b exp=000", sq3); end
        step();
        checks++;
        if (sq3 !== 3'b111) begin errors++; $display("FAIL oor_rise got=%b exp=111", sq3); end
    endtask

`ifdef SQ_WAVE_GEN_SYNC_EN
    task automatic test_sync();
        int n;
        int s;
        do_reset();
        en = 1'b1;
        wr(0, 4, s);
        wr(1, 6, s);
        steps(10);
        sync_r = 1'b1;
        step();
        sync_r = 1'b0;
        checks++;
        if (busy !== 4'b0000) begin errors++; $display("FAIL sync_busy got=%b exp=0000", busy); end
        checks++;
        if (sq_out !== 4'b0000) begin errors++; $display("FAIL sync_out got=%b exp=0000", sq_out); end
        steps(24);
        checks++;
        if (sq_out[1:0] !== 2'b00) begin errors++; $display("FAIL sync_align got=%b exp=00", sq_out[1:0]); end
        cycles_to_toggle(0, n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL sync_ch0 got=%0d exp=4", n); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_mid();
        test_back_to_back();
        test_idle();
        test_enable();
        test_async_reset();
        test_out_of_range();
`ifdef SQ_WAVE_GEN_SYNC_EN
        test_sync();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
